// File: rtl/byte_striping_n.sv
// Serial-to-parallel byte striper: consecutive accepted bytes fill lanes 0..LANES-1
// and each complete (or flushed partial) group is presented for one cycle.
module byte_striping_n #(
  parameter int DATA_W = 8,
  parameter int LANES  = 2
) (
  input  logic                      clk_2f,
  input  logic                      reset,
  input  logic [DATA_W-1:0]         data_in,
  input  logic                      valid_in,
  input  logic                      flush,
  output logic [LANES*DATA_W-1:0]   lane_data,
  output logic [LANES-1:0]          lane_valid,
  output logic [15:0]               grp_cnt
);

  localparam int PTR_W = $clog2(LANES);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {FILL, EMIT} state_t;

  state_t                          state_reg, state_next;
  logic [PTR_W-1:0]                ptr_reg, ptr_next;
  logic [LANES-1:0][DATA_W-1:0]    stage_reg, stage_next;
  logic [LANES*DATA_W-1:0]         lane_data_reg;
  logic [LANES-1:0]                lane_valid_reg, lane_valid_next;
  logic [15:0]                     grp_cnt_reg;

  logic [CNT_W-1:0]                cnt_after;
  logic                            full;
  logic                            emit;
  logic [LANES-1:0]                slot_used;
  logic [LANES*DATA_W-1:0]         group_data;

  // Occupancy including this cycle's byte decides both full-group and flush emission.
  assign cnt_after = {1'b0, ptr_reg} + CNT_W'(valid_in);
  assign full      = (cnt_after == CNT_W'(LANES));
  assign emit      = full || (flush && (cnt_after != '0));

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_slot
      logic [DATA_W-1:0] slot_val;
      assign slot_val      = (valid_in && (ptr_reg == PTR_W'(gi))) ? data_in : stage_reg[gi];
      assign slot_used[gi] = (cnt_after > CNT_W'(gi));
      assign group_data[gi*DATA_W +: DATA_W] = slot_used[gi] ? slot_val : '0;
      assign stage_next[gi] = emit ? '0 : slot_val;
    end
  endgenerate

  // EMIT overlaps the next FILL, so the pointer logic is identical in both states.
  always_comb begin
    state_next      = state_reg;
    ptr_next        = ptr_reg + PTR_W'(valid_in);
    lane_valid_next = '0;
    case (state_reg)
      FILL:    if (emit) state_next = EMIT;
      EMIT:    if (!emit) state_next = FILL;
      default: state_next = FILL;
    endcase
    if (emit) begin
      ptr_next        = '0;
      lane_valid_next = slot_used;
    end
  end

  always_ff @(posedge clk_2f) begin
    if (reset) begin
      state_reg      <= FILL;
      ptr_reg        <= '0;
      stage_reg      <= '0;
      lane_data_reg  <= '0;
      lane_valid_reg <= '0;
      grp_cnt_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      ptr_reg        <= ptr_next;
      stage_reg      <= stage_next;
      lane_valid_reg <= lane_valid_next;
      if (emit) begin
        lane_data_reg <= group_data;
        grp_cnt_reg   <= grp_cnt_reg + 16'd1;
      end
    end
  end

  assign lane_data  = lane_data_reg;
  assign lane_valid = lane_valid_reg;
  assign grp_cnt    = grp_cnt_reg;

endmodule

// File: tb/tb_byte_striping_n.sv
// Drives a 2-lane and a 4-lane striper with the same byte stream and checks both
// against a queue-style group model.
module tb_byte_striping_n;

  logic        clk_2f = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  data_in = '0;
  logic        valid_in = 1'b0;
  logic        flush = 1'b0;

  logic [15:0] lane_data2;
  logic [1:0]  lane_valid2;
  logic [15:0] grp_cnt2;
  logic [31:0] lane_data4;
  logic [3:0]  lane_valid4;
  logic [15:0] grp_cnt4;

  int compared = 0;
  int mismatched = 0;

  // model state, index 0 = 2-lane instance, 1 = 4-lane instance
  int          nl [2] = '{2, 4};
  logic [7:0]  mbuf [2][8];
  int          mcnt [2];
  logic [63:0] exp_data [2];
  logic [7:0]  exp_valid [2];
  logic [15:0] exp_cnt [2];

  always #5 clk_2f = ~clk_2f;

  byte_striping_n #(.DATA_W(8), .LANES(2)) dut2 (
    .clk_2f(clk_2f), .reset(reset), .data_in(data_in), .valid_in(valid_in), .flush(flush),
    .lane_data(lane_data2), .lane_valid(lane_valid2), .grp_cnt(grp_cnt2)
  );

  byte_striping_n #(.DATA_W(8), .LANES(4)) dut4 (
    .clk_2f(clk_2f), .reset(reset), .data_in(data_in), .valid_in(valid_in), .flush(flush),
    .lane_data(lane_data4), .lane_valid(lane_valid4), .grp_cnt(grp_cnt4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input logic r, input logic v, input logic [7:0] d, input logic f);
    for (int i = 0; i < 2; i++) begin
      if (r) begin
        mcnt[i] = 0; exp_data[i] = '0; exp_valid[i] = '0; exp_cnt[i] = '0;
      end else begin
        if (v) begin
          mbuf[i][mcnt[i]] = d;
          mcnt[i]++;
        end
        if (mcnt[i] == nl[i] || (f && mcnt[i] > 0)) begin
          exp_data[i] = '0;
          for (int k = 0; k < mcnt[i]; k++) exp_data[i][k*8 +: 8] = mbuf[i][k];
          exp_valid[i] = 8'((1 << mcnt[i]) - 1);
          exp_cnt[i]++;
          mcnt[i] = 0;
        end else begin
          exp_valid[i] = '0;
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [7:0] d, input logic f,
                      input string tag);
    @(negedge clk_2f);
    reset = r; valid_in = v; data_in = d; flush = f;
    @(posedge clk_2f);
    model_update(r, v, d, f);
    #1;
    chk({tag, " valid2"}, 64'(lane_valid2), 64'(exp_valid[0]));
    chk({tag, " data2"},  64'(lane_data2),  exp_data[0]);
    chk({tag, " cnt2"},   64'(grp_cnt2),    64'(exp_cnt[0]));
    chk({tag, " valid4"}, 64'(lane_valid4), 64'(exp_valid[1]));
    chk({tag, " data4"},  64'(lane_data4),  exp_data[1]);
    chk({tag, " cnt4"},   64'(grp_cnt4),    64'(exp_cnt[1]));
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      mcnt[i] = 0; exp_data[i] = '0; exp_valid[i] = '0; exp_cnt[i] = '0;
    end

    // reset state
    step(1, 1, 8'hFF, 1, "reset");
    step(1, 0, 8'h00, 0, "reset");

    // continuous stream 01..0C
    for (int b = 1; b <= 12; b++) step(0, 1, 8'(b), 0, "stream");
    chk("stream grp_cnt2 six", 64'(grp_cnt2), 64'd6);
    chk("stream grp_cnt4 three", 64'(grp_cnt4), 64'd3);

    // gap between bytes
    step(0, 1, 8'h0D, 0, "gap");
    step(0, 0, 8'h55, 0, "gap idle");
    step(0, 0, 8'hAA, 0, "gap idle");
    step(0, 1, 8'h0E, 0, "gap");
    chk("gap lanes2", 64'(lane_data2), 64'h0E0D);

    // drain the 4-lane instance, then flush on empty (must emit nothing)
    step(0, 0, 8'h00, 1, "drain");
    step(0, 0, 8'h00, 1, "empty flush");

    // partial flush
    step(0, 1, 8'hA1, 0, "partial");
    step(0, 1, 8'hA2, 0, "partial");
    step(0, 1, 8'hA3, 0, "partial");
    step(0, 0, 8'h00, 1, "partial flush");
    chk("partial valid4", 64'(lane_valid4), 64'h7);
    chk("partial data4", 64'(lane_data4), 64'h00A3A2A1);
    step(0, 0, 8'h00, 1, "empty flush");

    // flush coincident with the completing byte
    step(0, 1, 8'hB1, 0, "complete");
    step(0, 1, 8'hB2, 0, "complete");
    step(0, 1, 8'hB3, 0, "complete");
    step(0, 1, 8'hB4, 1, "complete flush");
    chk("complete valid4", 64'(lane_valid4), 64'hF);
    chk("complete data4", 64'(lane_data4), 64'hB4B3B2B1);
    step(0, 0, 8'h00, 0, "complete after");

    // reset mid-group
    step(0, 1, 8'hC1, 0, "midreset");
    step(1, 0, 8'h00, 0, "midreset rst");
    step(0, 1, 8'hC2, 0, "midreset");
    step(0, 1, 8'hC3, 0, "midreset");
    chk("midreset data2", 64'(lane_data2), 64'hC3C2);
    chk("midreset cnt2", 64'(grp_cnt2), 64'd1);

    // randomized traffic
    for (int n = 0; n < 400; n++)
      step(($urandom_range(0, 40) == 0), ($urandom_range(0, 3) != 0), 8'($urandom),
           ($urandom_range(0, 4) == 0), "random");

    // counter wrap: one single-byte flushed group per cycle
    step(1, 0, 8'h00, 0, "wrap rst");
    for (int n = 0; n < 65535; n++) step(0, 1, 8'($urandom), 1, "wrap");
    chk("wrap cnt2 ffff", 64'(grp_cnt2), 64'hFFFF);
    step(0, 1, 8'h5A, 1, "wrap last");
    chk("wrap cnt2 zero", 64'(grp_cnt2), 64'h0);
    chk("wrap cnt4 zero", 64'(grp_cnt4), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/byte_striping_n.md
BYTE_STRIPING_N -- requirements
Module: byte_striping_n

Interface
REQ-001 The block SHALL have a parameter DATA_W, default 8, giving the width of one data unit (byte) in bits; legal values 1-32.
REQ-002 The block SHALL have a parameter LANES, default 2, giving the number of output lanes; legal values 2, 4, 8.
REQ-003 The block SHALL have a port clk_2f, input, width 1: the single clock; all logic on its rising edge.
REQ-004 The block SHALL have a port reset, input, width 1: synchronous, active-high reset.
REQ-005 The block SHALL have a port data_in, input, width DATA_W: the serial byte stream.
REQ-006 The block SHALL have a port valid_in, input, width 1: data_in is valid this cycle.
REQ-007 The block SHALL have a port flush, input, width 1: emit a pending partial group.
REQ-008 The block SHALL have a port lane_data, output, width LANES*DATA_W: lane k occupies bits [k*DATA_W +: DATA_W].
REQ-009 The block SHALL have a port lane_valid, output, width LANES: per-lane valid.
REQ-010 The block SHALL have a port grp_cnt, output, width 16: count of emitted groups.

Function
REQ-011 The block SHALL accept one byte on every cycle with valid_in=1; no backpressure exists.
REQ-012 The block SHALL hold a lane pointer ptr (0..LANES-1); each accepted byte is written to staging slot ptr, and ptr increments.
REQ-013 On a cycle with valid_in=0, the block SHALL leave ptr and staging unchanged, so gaps never break lane ordering.
REQ-014 When an accepted byte fills slot LANES-1, the block SHALL on the next edge drive all staged bytes onto lane_data with lane_valid all ones for exactly one cycle, and ptr wraps to 0.
REQ-015 Latency from the edge sampling the last byte of a group to lane_valid asserted SHALL be 1 clk_2f cycle, registered outputs only.
REQ-016 Byte order SHALL be: first byte of a group to lane 0, second to lane 1, and so on.
REQ-017 When flush=1 and ptr>0 (after accounting for the same-cycle byte), the block SHALL emit slots 0..ptr-1 with lane_valid bits set only for those slots, the remaining lanes 0 in data, and ptr reset to 0.
REQ-018 When flush=1 with valid_in=1, the block SHALL include the same-cycle byte in the flushed group; if that byte completes the group, a normal full group is emitted, identical to REQ-014.
REQ-019 When flush=1 with an empty staging buffer (ptr=0 and no valid byte), the block SHALL emit nothing.
REQ-020 On cycles without an emission, lane_valid SHALL be 0 and lane_data SHALL hold its previous value.
REQ-021 grp_cnt SHALL increment by 1 on every emission (full or partial) and wrap from 16'hFFFF to 0.
REQ-022 Staging SHALL be a state machine with two states: FILL (ptr accumulating) and EMIT (the output cycle). EMIT overlaps with FILL of the next group, so back-to-back full groups sustain 100% input rate.

Reset
REQ-023 While reset=1 at a clk_2f edge: ptr=0, staging cleared, lane_data=0, lane_valid=0, grp_cnt=0.
REQ-024 A reset asserted mid-group SHALL discard the partial group without emitting it; valid_in and flush are ignored during reset.
REQ-025 The first byte accepted after reset deasserts SHALL go to lane 0.

Verification
REQ-026 Scenario, LANES=2, DATA_W=8: reset, then valid bytes 01..0C continuously -> six groups {01,02},{03,04},...,{0B,0C} on lanes 0/1, each one cycle after its second byte; lane_valid=2'b11; grp_cnt=6.
REQ-027 Scenario, gap: bytes 0D, idle, idle, 0E -> single group {0D,0E} emitted one cycle after 0E; no output during the idles.
REQ-028 Scenario, LANES=4 partial flush: bytes A1, A2, A3, then flush=1 alone -> lane_valid=4'b0111, lanes 0-2 = A1,A2,A3, lane 3 = 00; the next byte goes to lane 0.
REQ-029 Scenario, flush with a completing byte, LANES=4: bytes B1, B2, B3, then B4 together with flush=1 -> one full group with 4'b1111; no extra emission.
REQ-030 Scenario, reset mid-group: byte C1 accepted, reset=1 for 1 cycle, then bytes C2, C3 -> only {C2,C3} emitted; C1 never appears; grp_cnt=1.
REQ-031 Scenario, wrap: preload grp_cnt to FFFF via 65535 groups (or force), one more group -> grp_cnt=0000.
